xcore_gnrl_rr_arbiter: RTL and testbench

- Sequential round-robin arbiter that shares one resource among REQ_NUM requesters in the Xcore general library.
- Produces a registered one-hot grant that drives the select (scl) input of the existing combinational selector, plus an encoded index and a valid flag.
- Grant is held while the owner keeps requesting; an optional hold limit forces rotation so no requester starves.

---
 rtl/xcore_arb_pkg.sv | 22 ++
 rtl/xcore_rr_pick.sv | 33 +++
 rtl/xcore_gnrl_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_xcore_gnrl_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/xcore_arb_pkg.sv
// Shared types and helpers for the Xcore general round-robin arbiter.
// Holds the arbiter state encoding and a one-hot to index converter.
package xcore_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_REQ_NUM = 4;
  localparam int unsigned ARB_PTR_RST = ARB_REQ_NUM - 1;

  function automatic logic [3:0] oh2idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx |= 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xcore_rr_pick.sv
// Combinational rotating priority pick: first eligible request
// after ptr_i, wrapping, with excluded requesters skipped.
module xcore_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int IDX_W   = 2
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic [REQ_NUM-1:0] excl_i,
  output logic [REQ_NUM-1:0] pick_o,
  output logic               any_o
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick_o = '0;
    found  = 1'b0;
    pos    = 0;
    idx    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      pos = (int'(ptr_i) + 1 + i) % REQ_NUM;
      idx = IDX_W'(pos);
      if (!found && req_i[idx] && !excl_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/xcore_gnrl_rr_arbiter.sv
// Registered round-robin arbiter with hold-limit preemption and lock.
// One-hot grant feeds the downstream selector's scl input directly.
module xcore_gnrl_rr_arbiter
  import xcore_arb_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req,
  input  logic               lock,
  output logic [REQ_NUM-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld,
  output logic               preempt
);

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(REQ_NUM - 1);
  localparam bit PRE_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_e         state_q, state_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               vld_q, vld_d;
  logic               pre_q, pre_d;

  logic [REQ_NUM-1:0] excl;
  logic [REQ_NUM-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               any;
  logic               own_req;
  logic               expired;

  // Outside of a tenure nobody is excluded from the search.
  assign excl = (state_q == GRANT) ? gnt_q : '0;

  xcore_rr_pick #(
    .REQ_NUM(REQ_NUM),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .excl_i(excl),
    .pick_o(pick),
    .any_o (any)
  );

  assign pick_idx = IDX_W'(oh2idx(16'(pick)));
  assign own_req  = |(req & gnt_q);
  // >= so a saturated counter still preempts once lock drops.
  assign expired  = PRE_EN && (hold_q >= HOLD_LAST) && !lock;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          gnt_d   = pick;
          idx_d   = pick_idx;
          ptr_d   = pick_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_req) begin
          if (any) begin
            gnt_d  = pick;
            idx_d  = pick_idx;
            ptr_d  = pick_idx;
            hold_d = '0;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (expired && any) begin
          gnt_d  = pick;
          idx_d  = pick_idx;
          ptr_d  = pick_idx;
          hold_d = '0;
          pre_d  = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
    vld_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;
  assign preempt = pre_q;

endmodule

// File: tb/tb_xcore_gnrl_rr_arbiter.sv
// Bench for xcore_gnrl_rr_arbiter: vector table, directed corners,
// and random traffic against a tenure-based reference model.
module tb_xcore_gnrl_rr_arbiter;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int MAXH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic          lock = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;
  logic          preempt;

  int checks = 0;
  int fails  = 0;

  // reference model: owner (-1 idle), rotation pointer, cycles held
  int m_own = -1;
  int m_ptr = N - 1;
  int m_ten = 0;
  int m_idx = 0;
  bit m_pre = 1'b0;

  typedef struct {
    logic [N-1:0]  req;
    logic          lock;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          pre;
  } vec_t;

  vec_t tbl[12];
  logic [N-1:0] hist_g[40];
  logic         hist_p[40];

  xcore_gnrl_rr_arbiter #(
    .REQ_NUM (N),
    .IDX_W   (IW),
    .MAX_HOLD(MAXH),
    .HOLD_W  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lock   (lock),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .preempt(preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit has(input logic [N-1:0] r, input int c);
    return ((r >> c) & 4'd1) == 4'd1;
  endfunction

  function automatic int mpick(input logic [N-1:0] r, input int ex);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (c != ex && has(r, c)) return c;
    end
    return -1;
  endfunction

  task automatic model_rst();
    m_own = -1;
    m_ptr = N - 1;
    m_ten = 0;
    m_idx = 0;
    m_pre = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic lk);
    int p;
    m_pre = 1'b0;
    if (m_own < 0) begin
      p = mpick(r, -1);
      if (p >= 0) begin m_own = p; m_ptr = p; m_ten = 1; end
    end else if (!has(r, m_own)) begin
      p = mpick(r, m_own);
      if (p >= 0) begin m_own = p; m_ptr = p; m_ten = 1; end
      else m_own = -1;
    end else begin
      p = mpick(r, m_own);
      if (MAXH != 0 && m_ten >= MAXH && !lk && p >= 0) begin
        m_own = p; m_ptr = p; m_ten = 1; m_pre = 1'b1;
      end else begin
        m_ten++;
      end
    end
    if (m_own >= 0) m_idx = m_own;
  endtask

  function automatic logic [N-1:0] m_gnt();
    return (m_own < 0) ? '0 : N'(1 << m_own);
  endfunction

  // apply inputs just after an edge, clock once, compare with model
  task automatic cyc(input logic [N-1:0] r, input logic lk);
    req  = r;
    lock = lk;
    @(posedge clk);
    model_edge(r, lk);
    #1;
    chk("m_gnt", 32'(gnt), 32'(m_gnt()));
    chk("m_idx", 32'(gnt_idx), 32'(m_idx));
    chk("m_vld", 32'(gnt_vld), 32'(m_own >= 0));
    chk("m_pre", 32'(preempt), 32'(m_pre));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    lock = 1'b0;
    model_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int run;
    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[4]  = '{4'b1110, 1'b0, 4'b0010, 2'd1, 1'b0};
    tbl[5]  = '{4'b1101, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[6]  = '{4'b1011, 1'b0, 4'b1000, 2'd3, 1'b0};
    tbl[7]  = '{4'b0111, 1'b0, 4'b0001, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    tbl[9]  = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0};
    tbl[10] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_idx", 32'(gnt_idx), 0);
    chk("rst_vld", 32'(gnt_vld), 0);
    chk("rst_pre", 32'(preempt), 0);
    rst = 1'b0;
    model_rst();

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].req, tbl[i].lock);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_idx", i), 32'(gnt_idx), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_vld", i), 32'(gnt_vld), 32'(|tbl[i].gnt));
      chk($sformatf("tbl%0d_pre", i), 32'(preempt), 32'(tbl[i].pre));
    end

    // hold limit rotation with two contenders
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0011, 1'b0);
      hist_g[i] = gnt;
      hist_p[i] = preempt;
    end
    run = 0;
    while (run < 20 && hist_g[run] == 4'b0001) run++;
    chk("hold_run0", 32'(run), 8);
    chk("hold_g8", 32'(hist_g[8]), 32'(4'b0010));
    chk("hold_p8", 32'(hist_p[8]), 1);
    chk("hold_p9", 32'(hist_p[9]), 0);
    chk("hold_g16", 32'(hist_g[16]), 32'(4'b0001));
    chk("hold_p16", 32'(hist_p[16]), 1);

    // lock suppresses preemption until dropped
    do_reset();
    run = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0011, 1'b1);
      if (gnt == 4'b0001 && !preempt) run++;
    end
    chk("lock_run", 32'(run), 20);
    cyc(4'b0011, 1'b0);
    chk("unlock_gnt", 32'(gnt), 32'(4'b0010));
    chk("unlock_pre", 32'(preempt), 1);

    // release coinciding with expiry: release path wins
    do_reset();
    for (int i = 0; i < 8; i++) cyc(4'b0101, 1'b0);
    chk("coinc_pre_g", 32'(gnt), 32'(4'b0001));
    cyc(4'b0100, 1'b0);
    chk("coinc_gnt", 32'(gnt), 32'(4'b0100));
    chk("coinc_pre", 32'(preempt), 0);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_vld", 32'(gnt_vld), 0);
    model_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'b1111, 1'b0);
    chk("post_rst_gnt", 32'(gnt), 32'(4'b0001));

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic         lk;
      r  = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = '0;
      lk = ($urandom_range(0, 3) == 0);
      cyc(r, lk);
      chk("onehot", 32'($countones(gnt) <= 1), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
